iot_fleet_monitor: RTL and testbench
====================================

# iot_fleet_monitor

Multi-channel successor to the single-counter active IoT devices monitor. Tracks the number of active devices in each of `CHANNELS` independent device groups, each with a `WIDTH`-bit up/down counter. Adds a selectable wrap or saturate mode, per-channel synchronous clear, a registered threshold alarm, a sticky overflow flag and an optional fleet-wide total. Sits between the device-event decoder and the status/telemetry register bank.

## Interface
- `CHANNELS`, 4: number of independent device groups (≥1).
- `WIDTH`, 8: counter width per channel (≥2).
- `SATURATE`, 0: 0 = wrap-around arithmetic; 1 = clamp at 0 and 2^WIDTH−1.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `change` in CHANNELS: bit i=1 requests a count step on channel i this cycle.
- `on_off` in CHANNELS: bit i=1 steps up, 0 steps down; ignored when `change[i]`=0.
- `clear` in CHANNELS: bit i=1 synchronously zeroes channel i.
- `threshold` in WIDTH: alarm level shared by all channels.
- `counter_out` out CHANNELS*WIDTH: channel i at bits [i*WIDTH +: WIDTH].
- `alarm` out CHANNELS: bit i=1 when channel i count ≥ `threshold`.
- `overflow` out CHANNELS: sticky, set when channel i wraps or hits a clamp.
- `total_out` out WIDTH+$clog2(CHANNELS)+1: sum of all channel counts.

## Operation
- Per channel, per rising edge, priority: `clear` > `change` > hold.
  - `clear[i]`=1: count←0, `overflow[i]`←0; `change[i]`/`on_off[i]` ignored that cycle.
  - `change[i]`=1, `on_off[i]`=1: count+1; `change[i]`=1, `on_off[i]`=0: count−1.
  - `change[i]`=0: count holds.
- `SATURATE`=0: max+1→0 and 0−1→max; either wrap sets `overflow[i]`.
- `SATURATE`=1: an up step at max holds max, a down step at 0 holds 0; the blocked step sets `overflow[i]`.
- `overflow[i]` stays set until `clear[i]` or `rst`. Set and clear on the same edge is impossible because clear wins.
- `alarm[i]` is registered as (next count ≥ `threshold`), using `threshold` sampled on the same edge. It is always consistent with the `counter_out` value presented in the same cycle. `threshold`=0 means the alarm is always asserted after the first edge out of reset.
- Channels are fully independent. Simultaneous events on all channels are each applied in the same cycle.
- `total_out` is an unsigned, non-wrapping sum of the registered `counter_out` channels.

## Timing
- Reset values (asynchronous, immediate on `rst`=1): `counter_out`=0, `overflow`=0, `alarm`=0, `total_out`=0.
- First edge after `rst` deasserts: normal update. `alarm` then reflects 0 ≥ `threshold`.
- `counter_out`, `alarm`, `overflow`: 1-cycle latency from the input edge.
- `total_out`: 2-cycle latency from the input edge. It is one register stage behind `counter_out` and equals the sum of the `counter_out` values from the previous cycle.
- `rst` asserted mid-operation discards any in-flight total and zeroes all state without waiting for a clock edge.

## Configuration
- `IOT_FLEET_TOTAL_EN` defined: the total adder tree and its pipeline register are compiled in, behaving as above.
- `IOT_FLEET_TOTAL_EN` undefined: no adder or register is built; `total_out` is a constant 0. All other behaviour is unchanged.

## Test plan
- Reset then count: apply `rst` pulse; `change`=4'b0001, `on_off`=4'b0001 for 3 cycles → ch0=3, others 0; `total_out`=3 one cycle after ch0 reaches 3.
- Wrap (`SATURATE`=0, `WIDTH`=8): ch1 at 0, one down step → ch1=255, `overflow[1]`=1. A further up step → 0, and `overflow[1]` stays 1.
- Saturate (`SATURATE`=1): ch2 at 255, up step → ch2=255, `overflow[2]`=1. Ch2 at 0, down step → 0, overflow remains set.
- Clear priority: ch3=10 with `clear[3]`=1 and `change[3]`=1 on the same edge → ch3=0, `overflow[3]`=0.
- Alarm: `threshold`=5, ch0 stepped 4→5 → `alarm[0]`=1 in the same cycle as `counter_out` shows 5. Stepped 5→4 → `alarm[0]`=0.
- Async reset mid-run: all channels nonzero, assert `rst` between clock edges → all outputs 0 before the next edge. With the macro undefined, `total_out`=0 throughout.

Source files
------------

// File: rtl/iot_fleet_monitor.sv
// iot_fleet_monitor: per-channel active-device counters for a fleet of
// device groups.
//
// Each of CHANNELS groups has a WIDTH-bit up/down counter. Per channel and per
// clock edge the priority is clear > change > hold. SATURATE selects how a
// counter behaves at its limits:
//   0 - wrap-around
//   1 - clamp at 0 and at the maximum value
// A wrap or a blocked step sets that channel's sticky overflow flag. Only
// clear or rst removes it.
//
// The alarm is registered from the next count and the threshold value present
// on the same edge. It therefore always matches the counter_out value shown in
// the same cycle.
//
// Optional feature, macro IOT_FLEET_TOTAL_EN:
//   defined   - a fleet-wide total is built, registered one stage behind
//               counter_out.
//   undefined - total_out is tied to 0.
//
// This block has no handshake. Inputs are sampled on every rising edge, and
// outputs are valid in the cycle after the edge that produced them.

module iot_fleet_monitor #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS-1:0]                 change,
  input  logic [CHANNELS-1:0]                 on_off,
  input  logic [CHANNELS-1:0]                 clear,
  input  logic [WIDTH-1:0]                    threshold,
  output logic [CHANNELS*WIDTH-1:0]           counter_out,
  output logic [CHANNELS-1:0]                 alarm,
  output logic [CHANNELS-1:0]                 overflow,
  output logic [WIDTH+$clog2(CHANNELS):0]     total_out
);

  localparam int              TOTAL_W = WIDTH + $clog2(CHANNELS) + 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q;
  logic [CHANNELS-1:0][WIDTH-1:0] cnt_d;
  logic [CHANNELS-1:0]            ovf_q;
  logic [CHANNELS-1:0]            ovf_d;
  logic [CHANNELS-1:0]            alarm_q;
  logic [CHANNELS-1:0]            alarm_d;

  // Next-state logic per channel. Clear wins over change, and change wins
  // over hold. A step that would cross a limit either wraps or clamps, and in
  // both cases it sets the sticky overflow flag.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    alarm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clear[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (change[i]) begin
        if (on_off[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            ovf_d[i] = 1'b1;
            cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end else begin
          if (cnt_q[i] == '0) begin
            ovf_d[i] = 1'b1;
            cnt_d[i] = (SATURATE != 0) ? '0 : CNT_MAX;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
      end
      // The alarm is derived from the next count, so after the edge it lines
      // up with counter_out.
      alarm_d[i] = (cnt_d[i] >= threshold);
    end
  end

  // Counter, overflow and alarm registers. Reset clears them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ovf_q   <= '0;
      alarm_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      alarm_q <= alarm_d;
    end
  end

  assign counter_out = cnt_q;
  assign overflow    = ovf_q;
  assign alarm       = alarm_q;

`ifdef IOT_FLEET_TOTAL_EN
  logic [TOTAL_W-1:0] sum_d;
  logic [TOTAL_W-1:0] total_q;

  // Unsigned sum of the registered counts. The width is sized so that the
  // sum can never wrap.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum_d = sum_d + TOTAL_W'(cnt_q[i]);
    end
  end

  // Total pipeline stage. It sits one cycle behind counter_out, and reset
  // discards any in-flight sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
    end else begin
      total_q <= sum_d;
    end
  end

  assign total_out = total_q;
`else
  assign total_out = TOTAL_W'(0);
`endif

endmodule

// File: tb/tb_iot_fleet_monitor.sv
// Testbench for iot_fleet_monitor.
//
// Two instances share the same stimulus:
//   dut_w - wrap mode
//   dut_s - saturate mode
// A small reference model computes the expected outputs when stimulus is
// driven. The expected outputs are pushed to exp_q, then popped and compared
// one cycle later. The expected total follows IOT_FLEET_TOTAL_EN.

module tb_iot_fleet_monitor;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int TW   = W + $clog2(CH) + 1;
  localparam int EW   = CH*W + CH + CH + TW;   // one instance's outputs
  localparam int QW   = 2*EW;

  logic            clk;
  logic            rst;
  logic [CH-1:0]   change;
  logic [CH-1:0]   on_off;
  logic [CH-1:0]   clear;
  logic [W-1:0]    threshold;

  logic [CH*W-1:0] cnt_w, cnt_s;
  logic [CH-1:0]   alarm_w, alarm_s;
  logic [CH-1:0]   ovf_w, ovf_s;
  logic [TW-1:0]   tot_w, tot_s;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [QW-1:0] exp_q[$];

  // reference model state, index 0 = wrap, 1 = saturate
  int            m_cnt[2][CH];
  logic [CH-1:0] m_ovf[2];
  logic [CH-1:0] m_alarm[2];
  int            m_tot[2];

  iot_fleet_monitor #(.CHANNELS(CH), .WIDTH(W), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off), .clear(clear),
    .threshold(threshold), .counter_out(cnt_w), .alarm(alarm_w),
    .overflow(ovf_w), .total_out(tot_w)
  );

  iot_fleet_monitor #(.CHANNELS(CH), .WIDTH(W), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off), .clear(clear),
    .threshold(threshold), .counter_out(cnt_s), .alarm(alarm_s),
    .overflow(ovf_s), .total_out(tot_s)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < CH; i++) m_cnt[s][i] = 0;
      m_ovf[s]   = '0;
      m_alarm[s] = '0;
      m_tot[s]   = 0;
    end
  endtask

  task automatic model_step(input logic [CH-1:0] chg, input logic [CH-1:0] up,
                            input logic [CH-1:0] clr, input logic [W-1:0] thr);
    int maxv;
    int sum;
    maxv = (1 << W) - 1;
    for (int s = 0; s < 2; s++) begin
      sum = 0;
      for (int i = 0; i < CH; i++) sum += m_cnt[s][i];
      for (int i = 0; i < CH; i++) begin
        if (clr[i]) begin
          m_cnt[s][i] = 0;
          m_ovf[s][i] = 1'b0;
        end else if (chg[i] && up[i]) begin
          if (m_cnt[s][i] == maxv) begin
            m_ovf[s][i] = 1'b1;
            m_cnt[s][i] = (s == 1) ? maxv : 0;
          end else begin
            m_cnt[s][i] = m_cnt[s][i] + 1;
          end
        end else if (chg[i]) begin
          if (m_cnt[s][i] == 0) begin
            m_ovf[s][i] = 1'b1;
            m_cnt[s][i] = (s == 1) ? 0 : maxv;
          end else begin
            m_cnt[s][i] = m_cnt[s][i] - 1;
          end
        end
        m_alarm[s][i] = (m_cnt[s][i] >= int'(thr));
      end
`ifdef IOT_FLEET_TOTAL_EN
      m_tot[s] = sum;
`else
      m_tot[s] = 0;
`endif
    end
  endtask

  function automatic logic [EW-1:0] exp_of(input int s);
    logic [EW-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) v[i*W +: W] = W'(m_cnt[s][i]);
    v[CH*W +: CH]        = m_alarm[s];
    v[CH*W+CH +: CH]     = m_ovf[s];
    v[CH*W+2*CH +: TW]   = TW'(m_tot[s]);
    return v;
  endfunction

  task automatic compare_outputs(input logic [QW-1:0] e);
    logic [EW-1:0] ew, es;
    ew = e[EW-1:0];
    es = e[QW-1:EW];
    check("w_cnt",   64'(cnt_w),   64'(ew[CH*W-1:0]));
    check("w_alarm", 64'(alarm_w), 64'(ew[CH*W +: CH]));
    check("w_ovf",   64'(ovf_w),   64'(ew[CH*W+CH +: CH]));
    check("w_total", 64'(tot_w),   64'(ew[CH*W+2*CH +: TW]));
    check("s_cnt",   64'(cnt_s),   64'(es[CH*W-1:0]));
    check("s_alarm", 64'(alarm_s), 64'(es[CH*W +: CH]));
    check("s_ovf",   64'(ovf_s),   64'(es[CH*W+CH +: CH]));
    check("s_total", 64'(tot_s),   64'(es[CH*W+2*CH +: TW]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w_cnt"},   64'(cnt_w),   64'd0);
    check({tag, "_w_alarm"}, 64'(alarm_w), 64'd0);
    check({tag, "_w_ovf"},   64'(ovf_w),   64'd0);
    check({tag, "_w_total"}, 64'(tot_w),   64'd0);
    check({tag, "_s_cnt"},   64'(cnt_s),   64'd0);
    check({tag, "_s_alarm"}, 64'(alarm_s), 64'd0);
    check({tag, "_s_ovf"},   64'(ovf_s),   64'd0);
    check({tag, "_s_total"}, 64'(tot_s),   64'd0);
  endtask

  // driver: apply one cycle of stimulus, then score the result after the edge
  task automatic step(input logic [CH-1:0] chg, input logic [CH-1:0] up,
                      input logic [CH-1:0] clr, input logic [W-1:0] thr);
    logic [QW-1:0] e;
    @(negedge clk);
    change    = chg;
    on_off    = up;
    clear     = clr;
    threshold = thr;
    model_step(chg, up, clr, thr);
    exp_q.push_back({exp_of(1), exp_of(0)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare_outputs(e);
  endtask

  initial begin
    rst       = 1'b1;
    change    = '0;
    on_off    = '0;
    clear     = '0;
    threshold = 8'd200;
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset then count on ch0, plus one hold cycle to see the total catch up
    for (int k = 0; k < 3; k++) step(4'b0001, 4'b0001, 4'b0000, 8'd200);
    step(4'b0000, 4'b0000, 4'b0000, 8'd200);

    // wrap on ch1: down from 0, then up again
    step(4'b0010, 4'b0000, 4'b0000, 8'd200);
    step(4'b0010, 4'b0010, 4'b0000, 8'd200);

    // run ch2 past the top, then clear it and step down at 0
    for (int k = 0; k < 256; k++) step(4'b0100, 4'b0100, 4'b0000, 8'd200);
    step(4'b0000, 4'b0000, 4'b0100, 8'd200);
    step(4'b0100, 4'b0000, 4'b0000, 8'd200);

    // clear priority on ch3: count to 10, then clear and change on one edge
    for (int k = 0; k < 10; k++) step(4'b1000, 4'b1000, 4'b0000, 8'd200);
    step(4'b1000, 4'b1000, 4'b1000, 8'd200);

    // alarm at threshold 5 on ch0
    step(4'b0000, 4'b0000, 4'b0001, 8'd5);
    for (int k = 0; k < 5; k++) step(4'b0001, 4'b0001, 4'b0000, 8'd5);
    step(4'b0001, 4'b0000, 4'b0000, 8'd5);

    // random traffic on all channels
    for (int k = 0; k < 200; k++) begin
      logic [CH-1:0] c, u, x;
      logic [W-1:0]  t;
      c = CH'($urandom_range(0, 15));
      u = CH'($urandom_range(0, 15));
      x = ($urandom_range(0, 15) == 0) ? CH'($urandom_range(0, 15)) : '0;
      t = W'($urandom_range(0, 255));
      step(c, u, x, t);
    end

    // async reset mid-run: make every channel nonzero first
    step(4'b0000, 4'b0000, 4'b1111, 8'd200);
    for (int k = 0; k < 3; k++) step(4'b1111, 4'b1111, 4'b0000, 8'd2);
    step(4'b0000, 4'b0000, 4'b0000, 8'd2);
    @(negedge clk);
    change = '0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // first edge after reset with threshold 0: the alarm comes on from a zero count
    step(4'b0000, 4'b0000, 4'b0000, 8'd0);
    step(4'b0001, 4'b0001, 4'b0000, 8'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
